// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter with byte FIFO; MMIO_UART_PARITY_EN adds an even-parity bit.
// Latency: a byte pushed at edge N is popped at N+1 and txd falls after that edge; frame is 10 (11) bit times.
// Backpressure: none on the bus; a store to a full FIFO is dropped and sets the sticky ovf flag.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
`ifdef MMIO_UART_PARITY_EN
  localparam logic PAR_PRESENT = 1'b1;
`else
  localparam logic PAR_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;

  logic            full;
  logic            empty;
  logic            wr_txdata;
  logic            wr_status;
  logic            push;
  logic            pop;
  logic            baud_done;
  logic [7:0]      head;
  logic [31:0]     status;
  logic            unused_bits;

  assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = memwrite & hit & ~addr[2];
  assign wr_status = memwrite & hit & addr[2];

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push      = wr_txdata & ~full;
  assign baud_done = (baud == BAUD_LAST);
  // The FSM takes a byte either from IDLE or at the last STOP cycle, giving gapless frames.
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
  assign head      = mem[rd_ptr];
  assign tx_busy   = (state != IDLE) | ~empty;

  assign unused_bits = ^{addr[1:0], writedata[31:8]};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // full is the pre-edge value, so a same-cycle pop does not rescue the byte.
      if (wr_txdata && full) begin
        ovf <= 1'b1;
      end else if (wr_status && writedata[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shift <= head;
            baud  <= '0;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
              state <= PARITY;
              txd   <= ^shift;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef MMIO_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud  <= '0;
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (!empty) begin
              shift <= head;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = tx_busy;
    status[3]     = ovf;
    status[4]     = PAR_PRESENT;
    status[15:8]  = 8'(count);
  end

  // TXDATA reads as zero; only STATUS returns data.
  assign rdata = (hit && addr[2]) ? status : '0;

endmodule
